// File: rtl/prf_pkg.sv
// Shared types and reset-default timing for the pulse-repetition scheduler.
package prf_pkg;

  localparam int CFG_CNT_W  = 16;
  localparam int CFG_PIDX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    BLANK,
    RX,
    DEAD
  } state_t;

  localparam logic [CFG_CNT_W-1:0]  DEF_PRI    = 16'd1150;
  localparam logic [CFG_CNT_W-1:0]  DEF_TX     = 16'd100;
  localparam logic [CFG_CNT_W-1:0]  DEF_BLANK  = 16'd0;
  localparam logic [CFG_CNT_W-1:0]  DEF_RX     = 16'd1050;
  localparam logic [CFG_PIDX_W-1:0] DEF_NPULSE = 8'd1;

  localparam logic [CFG_CNT_W-1:0]  CNT_ONE  = 16'd1;
  localparam logic [CFG_PIDX_W-1:0] PIDX_ONE = 8'd1;

  typedef struct packed {
    logic [CFG_CNT_W-1:0]  pri;
    logic [CFG_CNT_W-1:0]  tx_len;
    logic [CFG_CNT_W-1:0]  blank_len;
    logic [CFG_CNT_W-1:0]  rx_len;
    logic [CFG_PIDX_W-1:0] npulse;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    pri:       DEF_PRI,
    tx_len:    DEF_TX,
    blank_len: DEF_BLANK,
    rx_len:    DEF_RX,
    npulse:    DEF_NPULSE
  };

  // Two guard bits keep the phase sum from wrapping before it is compared with pri.
  function automatic logic cfg_is_valid(input cfg_t c);
    logic [CFG_CNT_W+1:0] sum;
    sum = {2'b00, c.tx_len} + {2'b00, c.blank_len} + {2'b00, c.rx_len};
    return (c.tx_len != '0) && (c.rx_len != '0) && (c.npulse != '0) &&
           (sum <= {2'b00, c.pri});
  endfunction

endpackage

// File: rtl/prf_scheduler_if.sv
// Software-facing shadow-configuration port: valid/ready write plus sticky error flag.
interface prf_scheduler_if #(
  parameter int CNT_W  = prf_pkg::CFG_CNT_W,
  parameter int PIDX_W = prf_pkg::CFG_PIDX_W
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_pri;
  logic [CNT_W-1:0]  cfg_tx_len;
  logic [CNT_W-1:0]  cfg_blank_len;
  logic [CNT_W-1:0]  cfg_rx_len;
  logic [PIDX_W-1:0] cfg_npulse;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_pri, cfg_tx_len, cfg_blank_len, cfg_rx_len, cfg_npulse,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pri, cfg_tx_len, cfg_blank_len, cfg_rx_len, cfg_npulse,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/prf_cfg_shadow.sv
// Shadow/active configuration registers; the shadow is promoted to active only when
// the scheduler signals a CPI boundary (apply) and a validated write is pending.
module prf_cfg_shadow
  import prf_pkg::*;
(
  input  logic                 fclk,
  input  logic                 rst_n,
  prf_scheduler_if.slave       cfg,
  input  logic                 apply,
  output cfg_t                 active,
  output logic [CFG_CNT_W-1:0] next_tx_len
);

  cfg_t shadow;
  cfg_t wr_cfg;
  logic pend;
  logic wr;
  logic wr_ok;

  always_comb begin
    wr_cfg = '{
      pri:       cfg.cfg_pri,
      tx_len:    cfg.cfg_tx_len,
      blank_len: cfg.cfg_blank_len,
      rx_len:    cfg.cfg_rx_len,
      npulse:    cfg.cfg_npulse
    };
    wr          = cfg.cfg_valid && !pend;
    wr_ok       = cfg_is_valid(wr_cfg);
    next_tx_len = pend ? shadow.tx_len : active.tx_len;
  end

  assign cfg.cfg_ready = !pend;

  // Copy and write never coincide: a write needs pend low, a copy needs it high.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= DEF_CFG;
      shadow      <= DEF_CFG;
      pend        <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      if (apply && pend) begin
        active <= shadow;
        pend   <= 1'b0;
      end
      if (wr) begin
        if (wr_ok) begin
          shadow      <= wr_cfg;
          pend        <= 1'b1;
          cfg.cfg_err <= 1'b0;
        end else begin
          cfg.cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prf_scheduler.sv
// PRI sequencer: TX -> BLANK -> RX -> DEAD per pulse, pulses grouped into CPIs.
// Every output is registered from the next-state decode so it lines up with its phase.
module prf_scheduler
  import prf_pkg::*;
#(
  parameter int CNT_W  = CFG_CNT_W,
  parameter int PIDX_W = CFG_PIDX_W
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              start,
  prf_scheduler_if.slave    cfg,
  output logic              prf,
  output logic              rx_gate,
  output logic              rx_start,
  output logic [PIDX_W-1:0] pulse_idx,
  output logic              cpi_done,
  output logic              busy
);

  state_t            state, next_state;
  logic [CNT_W-1:0]  phase_cnt, next_cnt;
  logic [CNT_W-1:0]  dead_len;
  logic [CNT_W-1:0]  next_tx_len;
  logic [PIDX_W-1:0] next_pidx;
  logic              apply;
  logic              pri_end;
  logic              cpi_next;
  cfg_t              active;

  prf_cfg_shadow u_shadow (
    .fclk        (fclk),
    .rst_n       (rst_n),
    .cfg         (cfg),
    .apply       (apply),
    .active      (active),
    .next_tx_len (next_tx_len)
  );

  always_comb begin
    dead_len   = active.pri - active.tx_len - active.blank_len - active.rx_len;
    next_state = state;
    next_cnt   = phase_cnt;
    next_pidx  = pulse_idx;
    apply      = 1'b0;
    pri_end    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          next_state = TX;
          apply      = 1'b1;
          next_pidx  = '0;
          next_cnt   = next_tx_len - CNT_ONE;
        end
      end
      TX: begin
        if (phase_cnt != '0) begin
          next_cnt = phase_cnt - CNT_ONE;
        end else if (active.blank_len != '0) begin
          next_state = BLANK;
          next_cnt   = active.blank_len - CNT_ONE;
        end else begin
          next_state = RX;
          next_cnt   = active.rx_len - CNT_ONE;
        end
      end
      BLANK: begin
        if (phase_cnt != '0) begin
          next_cnt = phase_cnt - CNT_ONE;
        end else begin
          next_state = RX;
          next_cnt   = active.rx_len - CNT_ONE;
        end
      end
      RX: begin
        if (phase_cnt != '0) begin
          next_cnt = phase_cnt - CNT_ONE;
        end else if (dead_len != '0) begin
          next_state = DEAD;
          next_cnt   = dead_len - CNT_ONE;
        end else begin
          pri_end = 1'b1;
        end
      end
      DEAD: begin
        if (phase_cnt != '0) begin
          next_cnt = phase_cnt - CNT_ONE;
        end else begin
          pri_end = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase

    // Only a CPI boundary may pick up a pending shadow config for the next TX length.
    if (pri_end) begin
      if (!start) begin
        next_state = IDLE;
      end else if (pulse_idx >= active.npulse - PIDX_ONE) begin
        next_state = TX;
        apply      = 1'b1;
        next_pidx  = '0;
        next_cnt   = next_tx_len - CNT_ONE;
      end else begin
        next_state = TX;
        next_pidx  = pulse_idx + PIDX_ONE;
        next_cnt   = active.tx_len - CNT_ONE;
      end
    end

    cpi_next = (next_pidx >= active.npulse - PIDX_ONE) && (next_cnt == '0) &&
               ((next_state == DEAD) || ((next_state == RX) && (dead_len == '0)));
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_idx <= '0;
      prf       <= 1'b0;
      rx_gate   <= 1'b0;
      rx_start  <= 1'b0;
      cpi_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      phase_cnt <= next_cnt;
      pulse_idx <= next_pidx;
      prf       <= (next_state == TX);
      rx_gate   <= (next_state == RX);
      rx_start  <= (next_state == RX) && (state != RX);
      cpi_done  <= cpi_next;
      busy      <= (next_state != IDLE);
    end
  end

endmodule

// File: doc/prf_scheduler.md
# prf_scheduler

Pulse-repetition scheduler for the DBF front end, clocked on `fclk`. It sequences each pulse repetition interval (PRI) into transmit, blanking, receive-window and dead-time phases. It counts pulses into coherent processing intervals (CPIs) and tells downstream beamforming capture when each receive window opens and each CPI ends. Timing is taken from a shadow configuration that software loads through a valid/ready handshake; it is applied only at CPI boundaries.

## Interface
Parameters:
- `CNT_W`, 16: width of all phase-length fields and the phase counter.
- `PIDX_W`, 8: width of pulse count/index.

Ports:
- `fclk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; one clock, no other clock domains.
- `start`  in  1  level enable; high = run CPIs back-to-back, low = stop at next PRI boundary.
- `cfg_valid`  in  1  shadow config write request.
- `cfg_ready`  out  1  shadow register can accept a write.
- `cfg_pri`  in  CNT_W  PRI length in fclk cycles.
- `cfg_tx_len`  in  CNT_W  prf-high cycles.
- `cfg_blank_len`  in  CNT_W  cycles between tx end and rx start (0 allowed).
- `cfg_rx_len`  in  CNT_W  rx_gate-high cycles.
- `cfg_npulse`  in  PIDX_W  pulses per CPI.
- `prf`  out  1  transmit pulse.
- `rx_gate`  out  1  receive window.
- `rx_start`  out  1  single-cycle strobe, first cycle of each rx window.
- `pulse_idx`  out  PIDX_W  index of current pulse in CPI, 0..npulse-1.
- `cpi_done`  out  1  single-cycle strobe, last cycle of final PRI of a CPI.
- `busy`  out  1  high in any state but IDLE.
- `cfg_err`  out  1  sticky; set when an invalid shadow config is accepted. Cleared by the next valid write.

## Operation
- States: IDLE, TX, BLANK, RX, DEAD. One down-counter `phase_cnt`, loaded with (length−1) on state entry.
- Reset defaults: active = shadow = {pri 1150, tx 100, blank 0, rx 1050, npulse 1}. All outputs 0, `cfg_ready`=1, `cfg_err`=0.
- Handshake: a write occurs when `cfg_valid && cfg_ready`. The write captures all cfg fields into the shadow and sets `pend`. `cfg_ready` = !pend. `pend` clears when the shadow is copied to active.
- Valid config: tx_len≥1, rx_len≥1, npulse≥1, tx+blank+rx ≤ pri. Evaluate the sum at CNT_W+2 bits, with no wrap.
  - An invalid write still completes the handshake but is discarded: shadow unchanged, `pend` unchanged, `cfg_err` set.
- Active config update: shadow→active copy happens on IDLE exit and at each CPI boundary, only if `pend`.
- IDLE→TX when `start`=1.
- TX (tx_len cycles) → BLANK (blank_len cycles; skipped if 0) → RX (rx_len cycles) → DEAD (pri−tx−blank−rx cycles; skipped if 0).
- End of PRI:
  - if `start`=0 → IDLE;
  - else if pulse_idx = npulse−1 → `cpi_done`, pulse_idx←0, TX;
  - else pulse_idx+1, TX.
- `start` falling mid-PRI: the current PRI completes, with no truncation of tx/rx. `cpi_done` does not pulse unless that PRI was the last of the CPI.
- Async reset mid-operation: all outputs 0 immediately, state IDLE, config returns to defaults.

## Timing
- All outputs are registered and decoded from next-state, with no extra latency. `start` sampled high at edge k gives `prf`=1 during cycle k+1.
- `prf` high for exactly tx_len cycles. `rx_gate` high for exactly rx_len cycles, beginning tx+blank cycles after the `prf` rise.
- Period from one `prf` rise to the next is exactly pri cycles.
- `rx_start` coincides with the first `rx_gate` cycle. `cpi_done` coincides with the last cycle of the PRI: the DEAD cycle, or the RX cycle if dead=0.
- A config handshake completing in the same cycle as the CPI boundary copy is not applied until the next boundary.
- `start` re-asserted in the same cycle the FSM returns to IDLE: TX entered the following cycle.
- `pulse_idx` updates in the first TX cycle of each PRI.

## Structure
- `prf_pkg`:
  - state enum;
  - reset-default constants (DEF_PRI=1150, DEF_TX=100, DEF_BLANK=0, DEF_RX=1050, DEF_NPULSE=1);
  - config struct type.
- Sub-module `prf_cfg_shadow`: handshake, validity check, shadow/active registers, `cfg_err`. Top holds the FSM and counters.

## Test plan
- Reset release, `start`=1, defaults → `prf` high 100 cycles, `rx_gate` high cycles 100..1149, period 1150, `cpi_done` every PRI.
- Config pri=10, tx=2, blank=1, rx=4, npulse=3 → `prf` cycles 0–1, `rx_start`/`rx_gate` at 3, gate through 6, DEAD 7–9, pulse_idx 0,1,2, `cpi_done` at cycle 29 only.
- Same config, blank=0, pri=6 → DEAD skipped, `rx_gate` 2–5, `cpi_done` on the last RX cycle.
- Write tx=5, blank=3, rx=4, pri=10 → `cfg_err`=1, shadow unchanged. Then a valid write → `cfg_err`=0.
- Write new config mid-CPI → `cfg_ready`=0 until the boundary; new timing starts on the first PRI of the next CPI.
- Drop `start` during TX of pulse 1, then assert `rst_n`=0 mid-RX in a second run → the first run completes its PRI then IDLE with no `cpi_done`; the reset zeroes all outputs asynchronously.
